jpeg_rle_decoder: RTL and testbench

Run-length decoder for the JPEG coefficient path: consumes (run, level, eob) symbols and expands them into a stream of 64 quantized coefficients per 8x8 block. Each coefficient is tagged with its position and a last-of-block flag. It is the decode-side counterpart of the run-length encoder in the entropy stage. It sits between the symbol unpacker and the dequantizer.

---
 rtl/jpeg_pkg.sv | 28 ++
 rtl/jpeg_zigzag_lut.sv | 12 +
 rtl/jpeg_rle_decoder.sv | 123 ++++++++++++
 tb/tb_jpeg_rle_decoder.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG coefficient path: block geometry, the run-length decoder
// state type and the zigzag-to-raster position table.
package jpeg_pkg;

   localparam int unsigned BLK_COEFS = 64;
   localparam int unsigned LAST_IDX  = 63;
   localparam int unsigned ZRL_RUN   = 15;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_LEVEL,
      S_FILL
   } rle_state_t;

   // Entry k is the row-major position of the k-th coefficient in zigzag scan order.
   localparam logic [5:0] ZIGZAG [BLK_COEFS] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

endpackage

// File: rtl/jpeg_zigzag_lut.sv
// Combinational de-zigzag lookup: zigzag scan position to raster position.
// Only instantiated when JPEG_RLE_ZIGZAG_EN is defined.
module jpeg_zigzag_lut
   import jpeg_pkg::*;
(
   input  logic [5:0] zz_pos,
   output logic [5:0] raster
);

   assign raster = ZIGZAG[zz_pos];

endmodule

// File: rtl/jpeg_rle_decoder.sv
// Run-length decoder: expands (run, level, eob) symbols into 64 coefficients per block.
// Define JPEG_RLE_ZIGZAG_EN to report out_index in raster order instead of zigzag order.
module jpeg_rle_decoder
   import jpeg_pkg::*;
#(
   parameter int unsigned COEF_W = 12,
   parameter int unsigned RUN_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [RUN_W-1:0]  in_run,
   input  logic [COEF_W-1:0] in_level,
   input  logic              in_eob,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [COEF_W-1:0] out_coef,
   output logic [5:0]        out_index,
   output logic              out_last,
   output logic              out_err
);

   rle_state_t        state;
   logic [RUN_W-1:0]  run_cnt;
   logic [5:0]        pos;
   logic [COEF_W-1:0] level_q;
   logic              load_en;
   logic              accept;
   logic              at_last;
   logic              emit;
   logic [5:0]        idx_map;

   assign load_en  = !out_valid || out_ready;
   assign in_ready = (state == S_IDLE) && load_en;
   assign accept   = in_valid && in_ready;
   assign at_last  = (pos == 6'(LAST_IDX));
   assign emit     = (state != S_IDLE) || accept;

`ifdef JPEG_RLE_ZIGZAG_EN
   jpeg_zigzag_lut u_zigzag_lut (
      .zz_pos (pos),
      .raster (idx_map)
   );
`else
   assign idx_map = pos;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         run_cnt   <= '0;
         pos       <= '0;
         level_q   <= '0;
         out_valid <= 1'b0;
         out_coef  <= '0;
         out_index <= '0;
         out_last  <= 1'b0;
         out_err   <= 1'b0;
      end else if (load_en) begin
         out_valid <= emit;
         out_err   <= 1'b0;
         if (emit) begin
            out_index <= idx_map;
            out_last  <= at_last;
            pos       <= pos + 6'd1;
         end
         unique case (state)
            S_IDLE: begin
               if (accept) begin
                  if (in_eob) begin
                     out_coef <= '0;
                     state    <= at_last ? S_IDLE : S_FILL;
                  end else if (in_run == '0) begin
                     out_coef <= in_level;
                  end else begin
                     out_coef <= '0;
                     level_q  <= in_level;
                     // Leading zero lands on index 63 with more to come: drop the rest.
                     if (at_last) begin
                        out_err <= 1'b1;
                     end else begin
                        run_cnt <= in_run - RUN_W'(1);
                        state   <= (in_run == RUN_W'(1)) ? S_LEVEL : S_RUN;
                     end
                  end
               end
            end
            S_RUN: begin
               out_coef <= '0;
               if (at_last) begin
                  out_err <= 1'b1;
                  run_cnt <= '0;
                  state   <= S_IDLE;
               end else begin
                  run_cnt <= run_cnt - RUN_W'(1);
                  if (run_cnt == RUN_W'(1)) begin
                     state <= S_LEVEL;
                  end
               end
            end
            S_LEVEL: begin
               // A ZRL symbol arrives here with a zero level, giving its sixteenth zero.
               out_coef <= level_q;
               state    <= S_IDLE;
            end
            S_FILL: begin
               out_coef <= '0;
               if (at_last) begin
                  state <= S_IDLE;
               end
            end
         endcase
      end
   end

   hold_under_backpressure: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready) |=> (out_valid && $stable(out_coef) && $stable(out_index)));

   err_only_on_last: assert property (@(posedge clk) disable iff (!rst_n)
      out_err |-> out_last);

endmodule

// File: tb/tb_jpeg_rle_decoder.sv
// Self-checking bench for jpeg_rle_decoder against a symbol-level reference model.
module tb_jpeg_rle_decoder;

   localparam int COEF_W = 12;
   localparam int RUN_W  = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [RUN_W-1:0]  in_run;
   logic [COEF_W-1:0] in_level;
   logic              in_eob;
   logic              out_valid;
   logic              out_ready;
   logic [COEF_W-1:0] out_coef;
   logic [5:0]        out_index;
   logic              out_last;
   logic              out_err;

   always #5 clk = ~clk;

   jpeg_rle_decoder #(
      .COEF_W (COEF_W),
      .RUN_W  (RUN_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_run    (in_run),
      .in_level  (in_level),
      .in_eob    (in_eob),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_coef  (out_coef),
      .out_index (out_index),
      .out_last  (out_last),
      .out_err   (out_err)
   );

   typedef struct {
      int run;
      int level;
      bit eob;
   } sym_t;

   typedef struct {
      logic [11:0] coef;
      logic [5:0]  idx;
      bit          last;
      bit          err;
   } elem_t;

   sym_t  syms[$];
   elem_t exp_q[$];
   int    model_pos;
   int    model_blocks;
   int    zz[64];
   int    n_pass;
   int    n_total;

   // Zigzag order built by walking the anti-diagonals of the 8x8 block.
   function automatic void build_zz();
      int k;
      k = 0;
      for (int s = 0; s < 15; s++) begin
         int lo;
         int hi;
         lo = (s > 7) ? s - 7 : 0;
         hi = (s < 7) ? s : 7;
         if (s % 2 == 0) begin
            for (int r = hi; r >= lo; r--) begin
               zz[k] = r * 8 + (s - r);
               k++;
            end
         end else begin
            for (int r = lo; r <= hi; r++) begin
               zz[k] = r * 8 + (s - r);
               k++;
            end
         end
      end
   endfunction

   function automatic int map_idx(input int p);
`ifdef JPEG_RLE_ZIGZAG_EN
      return zz[p];
`else
      return p;
`endif
   endfunction

   function automatic void push_elem(input int coef, input bit err);
      elem_t e;
      e.coef = coef[11:0];
      e.idx  = 6'(map_idx(model_pos));
      e.last = (model_pos == 63);
      e.err  = err;
      exp_q.push_back(e);
      if (model_pos == 63) model_blocks++;
      model_pos = (model_pos + 1) % 64;
   endfunction

   function automatic void add_symbol(input int run, input int level, input bit eob);
      sym_t s;
      s.run   = run;
      s.level = level;
      s.eob   = eob;
      syms.push_back(s);
      if (eob) begin
         repeat (64 - model_pos) push_elem(0, 1'b0);
      end else begin
         for (int i = 0; i < run; i++) begin
            if (model_pos == 63) begin
               push_elem(0, 1'b1);
               return;
            end
            push_elem(0, 1'b0);
         end
         push_elem(level, 1'b0);
      end
   endfunction

   // Drives queued symbols and checks every output transfer; stop_after > 0 ends early.
   task automatic run_stream(input int ready_pct, input int stop_after,
                             output int first_acc, output int last_xfer);
      int    cyc;
      int    n_xfer;
      int    limit;
      elem_t e;
      cyc       = 0;
      n_xfer    = 0;
      first_acc = -1;
      last_xfer = -1;
      limit     = exp_q.size() * 8 + syms.size() * 4 + 200;
      while ((syms.size() > 0 || exp_q.size() > 0) && !(stop_after > 0 && n_xfer >= stop_after))
      begin
         @(negedge clk);
         cyc++;
         if (cyc > limit) begin
            $display("FAIL stream_timeout: %0d symbols and %0d elements left, required 0",
                     syms.size(), exp_q.size());
            n_total++;
            syms.delete();
            exp_q.delete();
            break;
         end
         out_ready = ($urandom_range(0, 99) < ready_pct);
         if (syms.size() > 0) begin
            in_valid = 1'b1;
            in_run   = syms[0].run[3:0];
            in_level = syms[0].level[11:0];
            in_eob   = syms[0].eob;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (out_valid && out_ready) begin
            n_xfer++;
            last_xfer = cyc;
            n_total++;
            if (exp_q.size() == 0) begin
               $display("FAIL extra_element: got coef=%0d idx=%0d, required no element",
                        $signed(out_coef), out_index);
            end else begin
               e = exp_q.pop_front();
               if ({out_coef, out_index, out_last, out_err} !== {e.coef, e.idx, e.last, e.err})
                  $display("FAIL element: got coef=%0d idx=%0d last=%b err=%b, required coef=%0d idx=%0d last=%b err=%b",
                           $signed(out_coef), out_index, out_last, out_err,
                           $signed(e.coef), e.idx, e.last, e.err);
               else
                  n_pass++;
            end
         end
         if (in_valid && in_ready) begin
            if (first_acc < 0) first_acc = cyc;
            void'(syms.pop_front());
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_run    = '0;
      in_level  = '0;
      in_eob    = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_total++;
      if ({out_valid, out_coef, out_index, out_last, out_err} !== 21'd0)
         $display("FAIL reset_outputs: got valid=%b coef=%0d idx=%0d last=%b err=%b, required all 0",
                  out_valid, out_coef, out_index, out_last, out_err);
      else
         n_pass++;
      n_total++;
      if (in_ready !== 1'b1)
         $display("FAIL reset_in_ready: got %b, required 1", in_ready);
      else
         n_pass++;
      model_pos = 0;
   endtask

   task automatic test_basic_block();
      int fa;
      int lx;
      add_symbol(0, 5, 1'b0);
      add_symbol(2, -3, 1'b0);
      add_symbol(0, 0, 1'b1);
      run_stream(100, 0, fa, lx);
      n_total++;
      if (lx - fa !== 64)
         $display("FAIL basic_cycles: got %0d cycles, required 64", lx - fa);
      else
         n_pass++;
   endtask

   task automatic test_eob_full();
      int fa;
      int lx;
      add_symbol(0, 0, 1'b1);
      run_stream(100, 0, fa, lx);
      n_total++;
      if (lx - fa !== 64)
         $display("FAIL eob_full_cycles: got %0d cycles, required 64", lx - fa);
      else
         n_pass++;
   endtask

   task automatic test_zrl_exact_fill();
      int fa;
      int lx;
      repeat (3) add_symbol(15, 0, 1'b0);
      add_symbol(11, 1, 1'b0);
      add_symbol(3, 7, 1'b0);
      add_symbol(0, 1, 1'b0);
      add_symbol(0, 0, 1'b1);
      run_stream(100, 0, fa, lx);
   endtask

   task automatic test_overflow();
      int fa;
      int lx;
      repeat (3) add_symbol(15, 0, 1'b0);
      add_symbol(10, 6, 1'b0);
      add_symbol(5, 9, 1'b0);
      add_symbol(0, 3, 1'b0);
      add_symbol(0, 0, 1'b1);
      run_stream(70, 0, fa, lx);
   endtask

   task automatic test_random_backpressure();
      int fa;
      int lx;
      int r;
      int lv;
      while (model_blocks < 300) begin
         r = $urandom_range(0, 99);
         if (r < 8) begin
            add_symbol(0, 0, 1'b1);
         end else if (r < 14) begin
            add_symbol(15, 0, 1'b0);
         end else begin
            lv = int'($urandom_range(0, 4095)) - 2048;
            if (lv == 0) lv = 1;
            if ($urandom_range(0, 1) == 0) add_symbol($urandom_range(0, 3), lv, 1'b0);
            else add_symbol($urandom_range(0, 15), lv, 1'b0);
         end
      end
      run_stream(50, 0, fa, lx);
   endtask

   task automatic test_reset_midblock();
      int fa;
      int lx;
      add_symbol(0, 0, 1'b1);
      run_stream(100, 20, fa, lx);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      n_total++;
      if (out_valid !== 1'b0)
         $display("FAIL midreset_valid: got %b, required 0", out_valid);
      else
         n_pass++;
      n_total++;
      if (in_ready !== 1'b1)
         $display("FAIL midreset_in_ready: got %b, required 1", in_ready);
      else
         n_pass++;
      rst_n = 1'b1;
      syms.delete();
      exp_q.delete();
      model_pos = 0;
      add_symbol(0, 4, 1'b0);
      add_symbol(0, 0, 1'b1);
      run_stream(100, 0, fa, lx);
   endtask

   initial begin
      n_pass       = 0;
      n_total      = 0;
      model_pos    = 0;
      model_blocks = 0;
      build_zz();
      test_reset();
      test_basic_block();
      test_eob_full();
      test_zrl_exact_fill();
      test_overflow();
      test_random_backpressure();
      test_reset_midblock();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
